pad_attr_readback: RTL and testbench
====================================

Name: pad_attr_readback

Overview:
Reads back the live attribute word of each DIO pad for pinmux CSR readback. This is the read-side counterpart of the pad attribute configuration path.
- Accepts single-pad or sweep commands.
- Issues one attribute read per pad over a shared request/grant/rvalid port to the pad attribute wrappers.
- Returns each result on a valid/ready response channel, tagged with the pad index and the pad's configured type.

Parameters:
NDioPads, 4, number of DIO pads (1..64)
AttrDw, 13, width of one pad attribute word
PadTypeW, 3, width of one pad_type_e entry
TimeoutCycles, 16, max cycles waiting for rvalid after grant (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high only in IDLE
cmd_sweep_i  in  1  1: read pads 0..NDioPads-1; 0: single pad
cmd_idx_i  in  $clog2(NDioPads)+1  pad index for single read
pad_type_i  in  NDioPads*PadTypeW  packed per-pad pad_type_e from the target config; pad k at bits [k*PadTypeW +: PadTypeW]
attr_req_o  out  1  read request to the pad wrappers
attr_idx_o  out  $clog2(NDioPads)+1  pad being read
attr_gnt_i  in  1  request accepted
attr_rvalid_i  in  1  read data valid
attr_rdata_i  in  AttrDw  read data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_idx_o  out  $clog2(NDioPads)+1  pad index of the response
rsp_type_o  out  PadTypeW  pad_type_i slice for rsp_idx_o
rsp_attr_o  out  AttrDw  attribute word, 0 on error
rsp_err_o  out  1  index out of range or timeout
done_o  out  1  one-cycle pulse after the last response of a command is accepted

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values:
  - FSM state is IDLE.
  - cmd_ready_o=1.
  - attr_req_o=0, rsp_valid_o=0, done_o=0.
  - All data outputs are 0; timeout counter is 0.
- States: IDLE, REQ, WAIT, RSP.
- IDLE:
  - On cmd_valid_i, latch mode and the starting index: cmd_idx_i for a single read, 0 for a sweep.
  - If single and cmd_idx_i >= NDioPads, go directly to RSP with err=1, attr=0, type=0; no attr_req_o is issued.
  - Otherwise go to REQ.
- REQ:
  - attr_req_o=1 and attr_idx_o=current index, both held stable until attr_gnt_i.
  - On gnt, go to WAIT and clear the timeout counter.
  - A gnt and rvalid in the same cycle is legal: capture the data and go straight to RSP.
- WAIT:
  - The counter increments each cycle.
  - On attr_rvalid_i, capture attr_rdata_i with err=0 and go to RSP.
  - If the counter reaches TimeoutCycles-1 without rvalid, go to RSP with err=1, attr=0.
  - An rvalid arriving in the same cycle as the timeout wins (err=0).
  - An rvalid outside WAIT (or outside REQ with gnt) is ignored.
- RSP:
  - rsp_valid_o=1; all rsp_* outputs are registered and held stable until rsp_ready_i.
  - rsp_type_o is registered from pad_type_i at the capture point.
  - On handshake:
    - Single read: return to IDLE and pulse done_o.
    - Sweep, index < NDioPads-1: increment index and go to REQ.
    - Sweep, last pad: return to IDLE and pulse done_o.
- Latency with immediate gnt, rvalid the cycle after gnt, and immediate ready: command accept to rsp_valid_o is 3 cycles per pad.
- Sweep errors: a timed-out pad produces an err response and the sweep continues.
- Commands during a busy operation are not accepted (cmd_ready_o=0); the command source must hold cmd_valid_i.
- rst_i asserted in any state returns everything to reset values in the next cycle.
  - Any outstanding pad read is abandoned.
  - No response or done_o is emitted for the interrupted command.

Test Plan:
- Reset then idle: rst_i high 2 cycles -> cmd_ready_o=1, attr_req_o=0, rsp_valid_o=0, done_o=0.
- Single read: cmd_idx_i=2, pad 2 type=3'h1, gnt immediate, rvalid next cycle with 13'h0A5 -> rsp idx=2, type=1, attr=0x0A5, err=0, rsp_valid_o 3 cycles after accept, done_o after ready.
- Out of range: cmd_idx_i=4 with NDioPads=4 -> no attr_req_o, rsp err=1, attr=0, done_o pulses.
- Sweep with backpressure: sweep, rvalid data = 0x100+idx, rsp_ready_i low 3 cycles on pad 1 -> four responses idx 0..3, outputs stable while stalled, single done_o after idx 3.
- Timeout and tie: pad 1 never returns rvalid -> err=1 response after 16 WAIT cycles, sweep continues to pad 2; separately, rvalid on the timeout cycle -> err=0 with the data.
- Reset mid-sweep: rst_i asserted in WAIT for pad 2 -> no further responses, no done_o; a late rvalid after reset is ignored; a new single command works normally.

Source files
------------

// File: rtl/pad_attr_readback_if.sv
`default_nettype none
// ============================================================================
// Module   : pad_attr_readback_if
// Brief    : Command, pad-attribute read and response signals of the pad
//            attribute readback block, grouped for port connection.
// Revision : 1.0 - initial release
// ============================================================================
interface pad_attr_readback_if #(
    parameter int N_DIO_PADS = 4,
    parameter int ATTR_DW    = 13,
    parameter int PAD_TYPE_W = 3
);
    localparam int IDX_W = $clog2(N_DIO_PADS) + 1;

    logic                               cmd_valid_i;
    logic                               cmd_ready_o;
    logic                               cmd_sweep_i;
    logic [IDX_W-1:0]                   cmd_idx_i;
    logic [N_DIO_PADS*PAD_TYPE_W-1:0]   pad_type_i;
    logic                               attr_req_o;
    logic [IDX_W-1:0]                   attr_idx_o;
    logic                               attr_gnt_i;
    logic                               attr_rvalid_i;
    logic [ATTR_DW-1:0]                 attr_rdata_i;
    logic                               rsp_valid_o;
    logic                               rsp_ready_i;
    logic [IDX_W-1:0]                   rsp_idx_o;
    logic [PAD_TYPE_W-1:0]              rsp_type_o;
    logic [ATTR_DW-1:0]                 rsp_attr_o;
    logic                               rsp_err_o;
    logic                               done_o;

    // Readback block side
    modport slave (
        input  cmd_valid_i, cmd_sweep_i, cmd_idx_i, pad_type_i,
        input  attr_gnt_i, attr_rvalid_i, attr_rdata_i, rsp_ready_i,
        output cmd_ready_o, attr_req_o, attr_idx_o,
        output rsp_valid_o, rsp_idx_o, rsp_type_o, rsp_attr_o, rsp_err_o, done_o
    );

    // Command source / pad wrapper / response sink side
    modport master (
        output cmd_valid_i, cmd_sweep_i, cmd_idx_i, pad_type_i,
        output attr_gnt_i, attr_rvalid_i, attr_rdata_i, rsp_ready_i,
        input  cmd_ready_o, attr_req_o, attr_idx_o,
        input  rsp_valid_o, rsp_idx_o, rsp_type_o, rsp_attr_o, rsp_err_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/pad_attr_readback.sv
`default_nettype none
// ============================================================================
// Module   : pad_attr_readback
// Brief    : Reads back the live attribute word of one DIO pad or of all pads
//            in sequence and returns each result tagged with index and type.
// Revision : 1.0 - initial release
// ============================================================================
module pad_attr_readback #(
    parameter int N_DIO_PADS     = 4,
    parameter int ATTR_DW        = 13,
    parameter int PAD_TYPE_W     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    pad_attr_readback_if.slave bus
);
    localparam int IDX_W = $clog2(N_DIO_PADS) + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] c_npads    = IDX_W'(N_DIO_PADS);
    localparam logic [IDX_W-1:0] c_last_pad = IDX_W'(N_DIO_PADS - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    state_e                r_state, w_state;
    logic                  r_sweep, w_sweep;
    logic [IDX_W-1:0]      r_idx, w_idx;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic [IDX_W-1:0]      r_rsp_idx, w_rsp_idx;
    logic [PAD_TYPE_W-1:0] r_rsp_type, w_rsp_type;
    logic [ATTR_DW-1:0]    r_rsp_attr, w_rsp_attr;
    logic                  r_rsp_err, w_rsp_err;
    logic                  r_done, w_done;
    logic [PAD_TYPE_W-1:0] w_pad_type;

    // Type of the pad currently addressed; only consulted for in-range indices
    always_comb begin
        w_pad_type = '0;
        for (int k = 0; k < N_DIO_PADS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_pad_type = bus.pad_type_i[k*PAD_TYPE_W +: PAD_TYPE_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_sweep    <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_rsp_idx  <= '0;
            r_rsp_type <= '0;
            r_rsp_attr <= '0;
            r_rsp_err  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_sweep    <= w_sweep;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_rsp_idx  <= w_rsp_idx;
            r_rsp_type <= w_rsp_type;
            r_rsp_attr <= w_rsp_attr;
            r_rsp_err  <= w_rsp_err;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_sweep    = r_sweep;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_rsp_idx  = r_rsp_idx;
        w_rsp_type = r_rsp_type;
        w_rsp_attr = r_rsp_attr;
        w_rsp_err  = r_rsp_err;
        w_done     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    w_sweep = bus.cmd_sweep_i;
                    if (bus.cmd_sweep_i) begin
                        w_idx   = '0;
                        w_state = ST_REQ;
                    end else if (bus.cmd_idx_i >= c_npads) begin
                        // Bad index is answered locally without touching the pads
                        w_idx      = bus.cmd_idx_i;
                        w_rsp_idx  = bus.cmd_idx_i;
                        w_rsp_type = '0;
                        w_rsp_attr = '0;
                        w_rsp_err  = 1'b1;
                        w_state    = ST_RSP;
                    end else begin
                        w_idx   = bus.cmd_idx_i;
                        w_state = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (bus.attr_gnt_i) begin
                    w_cnt = '0;
                    if (bus.attr_rvalid_i) begin
                        w_rsp_idx  = r_idx;
                        w_rsp_type = w_pad_type;
                        w_rsp_attr = bus.attr_rdata_i;
                        w_rsp_err  = 1'b0;
                        w_state    = ST_RSP;
                    end else begin
                        w_state = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                w_rsp_idx  = r_idx;
                w_rsp_type = w_pad_type;
                // Data arriving on the final wait cycle takes priority over the timeout
                if (bus.attr_rvalid_i) begin
                    w_rsp_attr = bus.attr_rdata_i;
                    w_rsp_err  = 1'b0;
                    w_state    = ST_RSP;
                end else if (r_cnt == c_cnt_last) begin
                    w_rsp_attr = '0;
                    w_rsp_err  = 1'b1;
                    w_state    = ST_RSP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            ST_RSP: begin
                if (bus.rsp_ready_i) begin
                    if (r_sweep && (r_idx != c_last_pad)) begin
                        w_idx   = r_idx + IDX_W'(1);
                        w_state = ST_REQ;
                    end else begin
                        w_done  = 1'b1;
                        w_state = ST_IDLE;
                    end
                end
            end

            default: w_state = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready_o = (r_state == ST_IDLE);
    assign bus.attr_req_o  = (r_state == ST_REQ);
    assign bus.attr_idx_o  = r_idx;
    assign bus.rsp_valid_o = (r_state == ST_RSP);
    assign bus.rsp_idx_o   = r_rsp_idx;
    assign bus.rsp_type_o  = r_rsp_type;
    assign bus.rsp_attr_o  = r_rsp_attr;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pad_attr_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_attr_readback
// Brief    : Directed self-checking bench for pad_attr_readback with a
//            behavioural pad wrapper responder and response logger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pad_attr_readback;
    localparam int NP  = 4;
    localparam int ADW = 13;
    localparam int PTW = 3;
    localparam int TO  = 16;
    localparam int IW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pad_attr_readback_if #(.N_DIO_PADS(NP), .ATTR_DW(ADW), .PAD_TYPE_W(PTW)) bus ();

    pad_attr_readback #(
        .N_DIO_PADS(NP), .ATTR_DW(ADW), .PAD_TYPE_W(PTW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [IW-1:0]  idx;
        logic [PTW-1:0] typ;
        logic [ADW-1:0] attr;
        logic           err;
    } rsp_t;

    typedef struct {
        int idx; int gd; int rd; int data;
        int etype; int eattr; int eerr; int ereq;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    // Responder configuration and state
    int             gnt_delay, rv_delay, never_idx;
    bit             sweep_data;
    logic [ADW-1:0] single_data;
    int             gwait, wcnt;
    bit             pend;
    logic [IW-1:0]  cur_idx;
    bit             gnt_now;

    // Observation
    rsp_t log_q[$];
    rsp_t hold;
    bit   holding, req_seen, rsp_seen_any;
    int   done_cnt, acc_cyc, first_rsp_cyc, stall_idx, stall_left, stall_seen;
    int   never_gnt_cyc, never_rsp_cyc;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ADW-1:0] data_for(input logic [IW-1:0] i);
        return sweep_data ? ADW'(256 + int'(i)) : single_data;
    endfunction

    function automatic rsp_t cur_rsp();
        rsp_t r;
        r.idx  = bus.rsp_idx_o;
        r.typ  = bus.rsp_type_o;
        r.attr = bus.rsp_attr_o;
        r.err  = bus.rsp_err_o;
        return r;
    endfunction

    // One clock cycle: drive from the negedge, sample at the next negedge
    task automatic cyc();
        bit acc_now;
        acc_now = 1'b0;
        gnt_now = 1'b0;
        bus.attr_gnt_i    = 1'b0;
        bus.attr_rvalid_i = 1'b0;
        bus.attr_rdata_i  = '0;
        if (bus.attr_req_o) req_seen = 1'b1;
        if (pend) begin
            wcnt++;
            if (wcnt == rv_delay) begin
                bus.attr_rvalid_i = 1'b1;
                bus.attr_rdata_i  = data_for(cur_idx);
                pend = 1'b0;
            end
        end else if (bus.attr_req_o) begin
            if (gwait >= gnt_delay) begin
                bus.attr_gnt_i = 1'b1;
                gwait   = 0;
                cur_idx = bus.attr_idx_o;
                gnt_now = 1'b1;
                if (int'(cur_idx) == never_idx) begin
                    never_gnt_cyc = cyc_no;
                end else if (rv_delay == 0) begin
                    bus.attr_rvalid_i = 1'b1;
                    bus.attr_rdata_i  = data_for(cur_idx);
                end else if (rv_delay > 0) begin
                    pend = 1'b1;
                    wcnt = 0;
                end
            end else begin
                gwait++;
            end
        end

        if (holding) begin
            chk("stall_idx",  int'(bus.rsp_idx_o),  int'(hold.idx));
            chk("stall_type", int'(bus.rsp_type_o), int'(hold.typ));
            chk("stall_attr", int'(bus.rsp_attr_o), int'(hold.attr));
            chk("stall_err",  int'(bus.rsp_err_o),  int'(hold.err));
        end
        bus.rsp_ready_i = 1'b1;
        if (bus.rsp_valid_o && int'(bus.rsp_idx_o) == stall_idx && stall_left > 0) begin
            bus.rsp_ready_i = 1'b0;
            stall_left--;
            stall_seen++;
            if (!holding) begin
                hold    = cur_rsp();
                holding = 1'b1;
            end
        end
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            log_q.push_back(cur_rsp());
            holding = 1'b0;
        end
        if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            acc_now = 1'b1;
            acc_cyc = cyc_no;
        end

        @(posedge clk);
        cyc_no++;
        @(negedge clk);
        if (acc_now) bus.cmd_valid_i = 1'b0;
        if (bus.rsp_valid_o) rsp_seen_any = 1'b1;
        if (bus.rsp_valid_o && first_rsp_cyc < 0) first_rsp_cyc = cyc_no;
        if (bus.rsp_valid_o && int'(bus.rsp_idx_o) == never_idx && never_rsp_cyc < 0)
            never_rsp_cyc = cyc_no;
        if (bus.done_o) done_cnt++;
    endtask

    task automatic clr();
        log_q.delete();
        holding = 1'b0; req_seen = 1'b0; rsp_seen_any = 1'b0;
        done_cnt = 0; acc_cyc = -1; first_rsp_cyc = -1;
        stall_idx = -1; stall_left = 0; stall_seen = 0;
        never_idx = -1; never_gnt_cyc = -1; never_rsp_cyc = -1;
        gwait = 0;
    endtask

    // Issue a command and run until done_o plus two settle cycles
    task automatic run_cmd(input bit sweep, input int idx);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_sweep_i = sweep;
        bus.cmd_idx_i   = IW'(idx);
        for (int n = 0; n < 400 && done_cnt == 0; n++) cyc();
        cyc();
        cyc();
    endtask

    task automatic chk_rsp(input string tag, input int k, input int eidx,
                           input int etype, input int eattr, input int eerr);
        if (log_q.size() > k) begin
            chk({tag, "_idx"},  int'(log_q[k].idx),  eidx);
            chk({tag, "_type"}, int'(log_q[k].typ),  etype);
            chk({tag, "_attr"}, int'(log_q[k].attr), eattr);
            chk({tag, "_err"},  int'(log_q[k].err),  eerr);
        end else begin
            chk({tag, "_missing"}, log_q.size(), k + 1);
        end
    endtask

    initial begin
        vecs[0] = '{idx: 2, gd: 0, rd: 1,  data: 'h0A5,  etype: 1, eattr: 'h0A5,  eerr: 0, ereq: 1};
        vecs[1] = '{idx: 0, gd: 2, rd: 3,  data: 'h1FFF, etype: 5, eattr: 'h1FFF, eerr: 0, ereq: 1};
        vecs[2] = '{idx: 3, gd: 0, rd: 0,  data: 'h0C3,  etype: 7, eattr: 'h0C3,  eerr: 0, ereq: 1};
        vecs[3] = '{idx: 4, gd: 0, rd: 1,  data: 'h777,  etype: 0, eattr: 0,      eerr: 1, ereq: 0};
        vecs[4] = '{idx: 7, gd: 0, rd: 1,  data: 'h777,  etype: 0, eattr: 0,      eerr: 1, ereq: 0};
        vecs[5] = '{idx: 1, gd: 1, rd: 16, data: 'h055,  etype: 2, eattr: 'h055,  eerr: 0, ereq: 1};
        vecs[6] = '{idx: 1, gd: 0, rd: 17, data: 'h0EE,  etype: 2, eattr: 0,      eerr: 1, ereq: 1};
        vecs[7] = '{idx: 3, gd: 0, rd: -1, data: 'h0FF,  etype: 7, eattr: 0,      eerr: 1, ereq: 1};

        bus.cmd_valid_i   = 1'b0;
        bus.cmd_sweep_i   = 1'b0;
        bus.cmd_idx_i     = '0;
        bus.pad_type_i    = {3'h7, 3'h1, 3'h2, 3'h5};
        bus.attr_gnt_i    = 1'b0;
        bus.attr_rvalid_i = 1'b0;
        bus.attr_rdata_i  = '0;
        bus.rsp_ready_i   = 1'b1;
        gnt_delay = 0; rv_delay = 1; sweep_data = 1'b0; single_data = '0;
        pend = 1'b0; wcnt = 0; cur_idx = '0;
        clr();

        @(negedge clk);
        cyc();
        cyc();
        chk("rst_cmd_ready", int'(bus.cmd_ready_o), 1);
        chk("rst_attr_req",  int'(bus.attr_req_o),  0);
        chk("rst_rsp_valid", int'(bus.rsp_valid_o), 0);
        chk("rst_done",      int'(bus.done_o),      0);
        chk("rst_rsp_attr",  int'(bus.rsp_attr_o),  0);
        chk("rst_rsp_err",   int'(bus.rsp_err_o),   0);
        rst = 1'b0;
        cyc();

        // Single reads from the vector table
        for (int i = 0; i < 8; i++) begin
            clr();
            gnt_delay   = vecs[i].gd;
            rv_delay    = vecs[i].rd;
            sweep_data  = 1'b0;
            single_data = ADW'(vecs[i].data);
            run_cmd(1'b0, vecs[i].idx);
            chk($sformatf("v%0d_count", i), log_q.size(), 1);
            chk_rsp($sformatf("v%0d", i), 0, vecs[i].idx, vecs[i].etype, vecs[i].eattr, vecs[i].eerr);
            chk($sformatf("v%0d_done", i), done_cnt, 1);
            chk($sformatf("v%0d_req", i), int'(req_seen), vecs[i].ereq);
        end

        // Accept-to-valid latency with immediate grant and data one cycle later
        clr();
        gnt_delay = 0; rv_delay = 1; sweep_data = 1'b0; single_data = 13'h0A5;
        run_cmd(1'b0, 2);
        chk("lat_single", first_rsp_cyc - acc_cyc, 3);
        chk_rsp("lat", 0, 2, 1, 'h0A5, 0);

        // Sweep with three stall cycles on pad 1
        clr();
        gnt_delay = 0; rv_delay = 1; sweep_data = 1'b1;
        stall_idx = 1; stall_left = 3;
        run_cmd(1'b1, 0);
        chk("sw_count", log_q.size(), 4);
        chk_rsp("sw0", 0, 0, 5, 'h100, 0);
        chk_rsp("sw1", 1, 1, 2, 'h101, 0);
        chk_rsp("sw2", 2, 2, 1, 'h102, 0);
        chk_rsp("sw3", 3, 3, 7, 'h103, 0);
        chk("sw_stalls", stall_seen, 3);
        chk("sw_done", done_cnt, 1);
        chk("sw_lat", first_rsp_cyc - acc_cyc, 3);

        // Sweep where pad 1 never answers
        clr();
        gnt_delay = 0; rv_delay = 1; sweep_data = 1'b1;
        never_idx = 1;
        run_cmd(1'b1, 0);
        chk("to_count", log_q.size(), 4);
        chk_rsp("to0", 0, 0, 5, 'h100, 0);
        chk_rsp("to1", 1, 1, 2, 0, 1);
        chk_rsp("to2", 2, 2, 1, 'h102, 0);
        chk_rsp("to3", 3, 3, 7, 'h103, 0);
        chk("to_wait_len", never_rsp_cyc - never_gnt_cyc, TO + 1);
        chk("to_done", done_cnt, 1);

        // Reset while waiting on pad 2 of a sweep
        clr();
        gnt_delay = 0; rv_delay = 4; sweep_data = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_sweep_i = 1'b1;
        bus.cmd_idx_i   = '0;
        begin
            bit reached;
            reached = 1'b0;
            for (int n = 0; n < 100 && !reached; n++) begin
                cyc();
                if (gnt_now && cur_idx == IW'(2)) reached = 1'b1;
            end
            chk("mr_reach_pad2", int'(reached), 1);
        end
        chk("mr_pre_count", log_q.size(), 2);
        rst = 1'b1;
        cyc();
        chk("mr_cmd_ready", int'(bus.cmd_ready_o), 1);
        chk("mr_attr_req",  int'(bus.attr_req_o),  0);
        chk("mr_rsp_valid", int'(bus.rsp_valid_o), 0);
        rst = 1'b0;
        rsp_seen_any = 1'b0;
        done_cnt = 0;
        repeat (20) cyc();
        chk("mr_no_rsp",   int'(rsp_seen_any), 0);
        chk("mr_no_done",  done_cnt, 0);
        chk("mr_count",    log_q.size(), 2);

        clr();
        gnt_delay = 0; rv_delay = 1; sweep_data = 1'b0; single_data = 13'h0AB;
        run_cmd(1'b0, 3);
        chk("mr_new_count", log_q.size(), 1);
        chk_rsp("mr_new", 0, 3, 7, 'h0AB, 0);
        chk("mr_new_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
